// File: rtl/filter_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : filter_sched_pkg
// Purpose  : Shared types, default geometry and the BPM slew helper for the
//            filter frame scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package filter_sched_pkg;

    localparam int DEF_IMG_W        = 320;
    localparam int DEF_IMG_H        = 240;
    localparam int FRAME_PIX        = DEF_IMG_W * DEF_IMG_H;
    localparam int DEF_MAX_BPM      = 200;
    localparam int DEF_BPM_STEP     = 4;
    localparam int DEF_STALE_FRAMES = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        ACTIVE    = 2'd2,
        DISARMING = 2'd3
    } sched_state_t;

    // Moves applied toward target by at most step; never overshoots target.
    function automatic logic [7:0] bpm_slew(input logic [7:0] applied,
                                            input logic [7:0] target,
                                            input logic [7:0] step);
        logic [8:0] a9;
        logic [8:0] t9;
        logic [8:0] s9;
        logic [7:0] res;
        a9 = {1'b0, applied};
        t9 = {1'b0, target};
        s9 = {1'b0, step};
        if (t9 >= a9) begin
            res = ((t9 - a9) <= s9) ? target : 8'(a9 + s9);
        end else begin
            res = ((a9 - t9) <= s9) ? target : 8'(a9 - s9);
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bpm_slew_limiter.sv
`default_nettype none
// ============================================================================
// Module   : bpm_slew_limiter
// Purpose  : Holds the BPM target, staleness counter and applied BPM; updates
//            applied BPM only when the scheduler commands it at a boundary.
// Revision : 1.0 - initial release
// ============================================================================
module bpm_slew_limiter
    import filter_sched_pkg::*;
#(
    parameter int MAX_BPM      = DEF_MAX_BPM,
    parameter int BPM_STEP     = DEF_BPM_STEP,
    parameter int STALE_FRAMES = DEF_STALE_FRAMES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_bpm_in,
    input  logic       i_bpm_valid,
    input  logic       i_eof,
    input  logic       i_load,
    input  logic       i_slew,
    input  logic       i_clear,
    output logic [7:0] o_applied,
    output logic       o_stale
);

    localparam int                 STALE_W      = $clog2(STALE_FRAMES + 1);
    localparam logic [STALE_W-1:0] c_STALE_SAT  = STALE_W'(STALE_FRAMES);
    localparam logic [STALE_W-1:0] c_STALE_LAST = STALE_W'(STALE_FRAMES - 1);
    localparam logic [7:0]         c_MAX_BPM    = 8'(MAX_BPM);
    localparam logic [7:0]         c_BPM_STEP   = 8'(BPM_STEP);

    logic [7:0]         r_target;
    logic [7:0]         r_applied;
    logic [STALE_W-1:0] r_stale_cnt;
    logic               r_stale;
    logic [7:0]         w_bpm_clamped;

    assign w_bpm_clamped = (i_bpm_in > c_MAX_BPM) ? c_MAX_BPM : i_bpm_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_target    <= '0;
            r_stale_cnt <= '0;
            r_stale     <= 1'b0;
        end else if (i_bpm_valid) begin
            r_target    <= w_bpm_clamped;
            r_stale_cnt <= '0;
            r_stale     <= 1'b0;
        end else if (i_eof) begin
            if (r_stale_cnt >= c_STALE_LAST) begin
                r_stale_cnt <= c_STALE_SAT;
                r_target    <= '0;
                r_stale     <= 1'b1;
            end else begin
                r_stale_cnt <= r_stale_cnt + 1'b1;
            end
        end
    end

    // The applied value reads r_target before any same-cycle capture lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_applied <= '0;
        end else if (i_clear) begin
            r_applied <= '0;
        end else if (i_load) begin
            r_applied <= r_target;
        end else if (i_slew) begin
            r_applied <= bpm_slew(r_applied, r_target, c_BPM_STEP);
        end
    end

    assign o_applied = r_applied;
    assign o_stale   = r_stale;

endmodule
`default_nettype wire

// File: rtl/filter_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : filter_frame_scheduler
// Purpose  : Counts accepted pixels and applies filter enable/mode/BPM changes
//            only on frame boundaries. FILTER_SCHED_SOF_RESYNC_EN adds a sof
//            resync input and a sync error counter.
// Revision : 1.0 - initial release
// ============================================================================
module filter_frame_scheduler
    import filter_sched_pkg::*;
#(
    parameter int IMG_W        = DEF_IMG_W,
    parameter int IMG_H        = DEF_IMG_H,
    parameter int MAX_BPM      = DEF_MAX_BPM,
    parameter int BPM_STEP     = DEF_BPM_STEP,
    parameter int STALE_FRAMES = DEF_STALE_FRAMES
) (
    input  logic                              clk,
    input  logic                              reset,
`ifdef FILTER_SCHED_SOF_RESYNC_EN
    input  logic                              sof,
    output logic [7:0]                        sync_err_count,
`endif
    input  logic                              enable_req,
    input  logic                              mode_req,
    input  logic [7:0]                        bpm_in,
    input  logic                              bpm_valid,
    input  logic                              pix_valid,
    input  logic                              pix_ready,
    output logic                              filter_enable,
    output logic                              filter_mode,
    output logic [7:0]                        BPM_estimate,
    output logic                              frame_done,
    output logic [$clog2(IMG_W*IMG_H)-1:0]    pixel_count,
    output logic                              bpm_stale,
    output logic [1:0]                        sched_state
);

    localparam int               FRAME_N    = IMG_W * IMG_H;
    localparam int               CNT_W      = $clog2(FRAME_N);
    localparam logic [CNT_W-1:0] c_LAST_PIX = CNT_W'(FRAME_N - 1);

    sched_state_t     r_state;
    sched_state_t     w_state_next;
    logic [CNT_W-1:0] r_pix_cnt;
    logic             r_frame_done;
    logic             r_filter_enable;
    logic             r_filter_mode;
    logic             w_accept;
    logic             w_eof;
    logic             w_load;
    logic             w_slew;
    logic             w_clear;
    logic             w_en_next;
    logic             w_mode_next;

    assign w_accept = pix_valid && pix_ready;

`ifdef FILTER_SCHED_SOF_RESYNC_EN
    logic [7:0] r_sync_err_count;

    // A sof starts a new frame, so the truncated one never produces an eof.
    assign w_eof = w_accept && !sof && (r_pix_cnt == c_LAST_PIX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_cnt <= '0;
        end else if (sof) begin
            r_pix_cnt <= w_accept ? CNT_W'(1) : '0;
        end else if (w_accept) begin
            r_pix_cnt <= w_eof ? '0 : r_pix_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_err_count <= '0;
        end else if (sof && (r_pix_cnt != '0) && (r_sync_err_count != 8'hFF)) begin
            r_sync_err_count <= r_sync_err_count + 1'b1;
        end
    end

    assign sync_err_count = r_sync_err_count;
`else
    assign w_eof = w_accept && (r_pix_cnt == c_LAST_PIX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_cnt <= '0;
        end else if (w_accept) begin
            r_pix_cnt <= w_eof ? '0 : r_pix_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_slew       = 1'b0;
        w_clear      = 1'b0;
        w_en_next    = r_filter_enable;
        w_mode_next  = r_filter_mode;
        case (r_state)
            IDLE: begin
                w_en_next = 1'b0;
                if (enable_req) begin
                    w_state_next = ARMED;
                end
            end
            ARMED: begin
                if (!enable_req) begin
                    w_state_next = IDLE;
                end else if (w_eof) begin
                    w_state_next = ACTIVE;
                    w_load       = 1'b1;
                    w_en_next    = 1'b1;
                    w_mode_next  = mode_req;
                end
            end
            ACTIVE: begin
                if (w_eof) begin
                    w_slew      = 1'b1;
                    w_mode_next = mode_req;
                end
                if (!enable_req) begin
                    w_state_next = DISARMING;
                end
            end
            DISARMING: begin
                if (enable_req) begin
                    w_state_next = ACTIVE;
                    if (w_eof) begin
                        w_slew      = 1'b1;
                        w_mode_next = mode_req;
                    end
                end else if (w_eof) begin
                    w_state_next = IDLE;
                    w_clear      = 1'b1;
                    w_en_next    = 1'b0;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_filter_enable <= 1'b0;
            r_filter_mode   <= 1'b0;
            r_frame_done    <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_filter_enable <= w_en_next;
            r_filter_mode   <= w_mode_next;
            r_frame_done    <= w_eof;
        end
    end

    bpm_slew_limiter #(
        .MAX_BPM      (MAX_BPM),
        .BPM_STEP     (BPM_STEP),
        .STALE_FRAMES (STALE_FRAMES)
    ) u_bpm_slew_limiter (
        .clk         (clk),
        .rst         (reset),
        .i_bpm_in    (bpm_in),
        .i_bpm_valid (bpm_valid),
        .i_eof       (w_eof),
        .i_load      (w_load),
        .i_slew      (w_slew),
        .i_clear     (w_clear),
        .o_applied   (BPM_estimate),
        .o_stale     (bpm_stale)
    );

    assign filter_enable = r_filter_enable;
    assign filter_mode   = r_filter_mode;
    assign frame_done    = r_frame_done;
    assign pixel_count   = r_pix_cnt;
    assign sched_state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_filter_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter_frame_scheduler
// Purpose  : Directed self-checking bench for filter_frame_scheduler on a
//            4x2 frame geometry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_filter_frame_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable_req;
    logic       mode_req;
    logic [7:0] bpm_in;
    logic       bpm_valid;
    logic       pix_valid;
    logic       pix_ready;
    logic       filter_enable;
    logic       filter_mode;
    logic [7:0] BPM_estimate;
    logic       frame_done;
    logic [2:0] pixel_count;
    logic       bpm_stale;
    logic [1:0] sched_state;
`ifdef FILTER_SCHED_SOF_RESYNC_EN
    logic       sof;
    logic [7:0] sync_err_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    filter_frame_scheduler #(
        .IMG_W        (4),
        .IMG_H        (2),
        .MAX_BPM      (200),
        .BPM_STEP     (4),
        .STALE_FRAMES (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
`ifdef FILTER_SCHED_SOF_RESYNC_EN
        .sof            (sof),
        .sync_err_count (sync_err_count),
`endif
        .enable_req     (enable_req),
        .mode_req       (mode_req),
        .bpm_in         (bpm_in),
        .bpm_valid      (bpm_valid),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .filter_enable  (filter_enable),
        .filter_mode    (filter_mode),
        .BPM_estimate   (BPM_estimate),
        .frame_done     (frame_done),
        .pixel_count    (pixel_count),
        .bpm_stale      (bpm_stale),
        .sched_state    (sched_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pix();
        pix_valid = 1'b1;
        pix_ready = 1'b1;
        step();
        pix_valid = 1'b0;
        pix_ready = 1'b0;
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) push_pix();
    endtask

    task automatic strobe_bpm(input logic [7:0] v);
        bpm_in    = v;
        bpm_valid = 1'b1;
        step();
        bpm_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_checks++;
        if ({filter_enable, filter_mode, BPM_estimate, frame_done, pixel_count, bpm_stale, sched_state} !== 17'h0) begin
            n_errors++;
            $display("FAIL reset_values: got en=%b mode=%b bpm=%0d fd=%b cnt=%0d stale=%b st=%0d want all 0",
                     filter_enable, filter_mode, BPM_estimate, frame_done, pixel_count, bpm_stale, sched_state);
        end
    endtask

    task automatic test_first_enable();
        int fd_pulses;
        fd_pulses = 0;
        enable_req = 1'b1;
        step();
        n_checks++;
        if (sched_state !== 2'd1) begin
            n_errors++;
            $display("FAIL arm_state: got %0d want 1", sched_state);
        end
        strobe_bpm(8'd120);
        for (int i = 0; i < 8; i++) begin
            pix_valid = 1'b1;
            pix_ready = 1'b0;
            step();
            fd_pulses += int'(frame_done);
            pix_ready = 1'b1;
            step();
            fd_pulses += int'(frame_done);
            pix_valid = 1'b0;
            pix_ready = 1'b0;
            if (i == 6) begin
                n_checks++;
                if ({filter_enable, frame_done, pixel_count} !== {1'b0, 1'b0, 3'd7}) begin
                    n_errors++;
                    $display("FAIL pre_eof: got en=%b fd=%b cnt=%0d want en=0 fd=0 cnt=7",
                             filter_enable, frame_done, pixel_count);
                end
            end
        end
        n_checks++;
        if ({filter_enable, BPM_estimate, frame_done, pixel_count, sched_state} !== {1'b1, 8'd120, 1'b1, 3'd0, 2'd2}) begin
            n_errors++;
            $display("FAIL first_eof: got en=%b bpm=%0d fd=%b cnt=%0d st=%0d want en=1 bpm=120 fd=1 cnt=0 st=2",
                     filter_enable, BPM_estimate, frame_done, pixel_count, sched_state);
        end
        step();
        fd_pulses += int'(frame_done);
        n_checks++;
        if (fd_pulses !== 1) begin
            n_errors++;
            $display("FAIL frame_done_pulses: got %0d want 1", fd_pulses);
        end
    endtask

    task automatic test_slew();
        logic [7:0] exp_tbl [6];
        exp_tbl = '{8'd124, 8'd128, 8'd132, 8'd136, 8'd140, 8'd140};
        strobe_bpm(8'd140);
        for (int f = 0; f < 6; f++) begin
            push_n(8);
            n_checks++;
            if (BPM_estimate !== exp_tbl[f]) begin
                n_errors++;
                $display("FAIL slew_frame%0d: got %0d want %0d", f, BPM_estimate, exp_tbl[f]);
            end
        end
        strobe_bpm(8'd250);
        push_n(8);
        n_checks++;
        if (BPM_estimate !== 8'd144) begin
            n_errors++;
            $display("FAIL slew_up_after_250: got %0d want 144", BPM_estimate);
        end
    endtask

    task automatic test_mode_disable();
        push_n(3);
        mode_req = 1'b1;
        push_pix();
        n_checks++;
        if (filter_mode !== 1'b0) begin
            n_errors++;
            $display("FAIL mode_midframe: got %b want 0", filter_mode);
        end
        push_n(4);
        n_checks++;
        if ({filter_mode, BPM_estimate} !== {1'b1, 8'd148}) begin
            n_errors++;
            $display("FAIL mode_at_eof: got mode=%b bpm=%0d want mode=1 bpm=148", filter_mode, BPM_estimate);
        end
        push_n(5);
        enable_req = 1'b0;
        step();
        n_checks++;
        if ({sched_state, filter_enable} !== {2'd3, 1'b1}) begin
            n_errors++;
            $display("FAIL disarming: got st=%0d en=%b want st=3 en=1", sched_state, filter_enable);
        end
        push_n(3);
        n_checks++;
        if ({sched_state, filter_enable, BPM_estimate} !== {2'd0, 1'b0, 8'd0}) begin
            n_errors++;
            $display("FAIL disable_eof: got st=%0d en=%b bpm=%0d want st=0 en=0 bpm=0",
                     sched_state, filter_enable, BPM_estimate);
        end
    endtask

    task automatic test_stale();
        logic [7:0] exp_bpm;
        mode_req   = 1'b0;
        enable_req = 1'b1;
        step();
        strobe_bpm(8'd20);
        push_n(8);
        n_checks++;
        if ({sched_state, BPM_estimate} !== {2'd2, 8'd20}) begin
            n_errors++;
            $display("FAIL stale_arm: got st=%0d bpm=%0d want st=2 bpm=20", sched_state, BPM_estimate);
        end
        push_n(6 * 8);
        n_checks++;
        if (bpm_stale !== 1'b0) begin
            n_errors++;
            $display("FAIL stale_early: got %b want 0 after 7 frames", bpm_stale);
        end
        push_n(8);
        n_checks++;
        if ({bpm_stale, BPM_estimate} !== {1'b1, 8'd20}) begin
            n_errors++;
            $display("FAIL stale_hit: got stale=%b bpm=%0d want stale=1 bpm=20", bpm_stale, BPM_estimate);
        end
        exp_bpm = 8'd20;
        for (int k = 0; k < 6; k++) begin
            push_n(8);
            exp_bpm = (exp_bpm >= 8'd4) ? exp_bpm - 8'd4 : 8'd0;
            n_checks++;
            if (BPM_estimate !== exp_bpm) begin
                n_errors++;
                $display("FAIL stale_ramp%0d: got %0d want %0d", k, BPM_estimate, exp_bpm);
            end
        end
        strobe_bpm(8'd60);
        n_checks++;
        if (bpm_stale !== 1'b0) begin
            n_errors++;
            $display("FAIL stale_clear: got %b want 0", bpm_stale);
        end
    endtask

    task automatic test_coincident();
        enable_req = 1'b0;
        step();
        push_n(8);
        n_checks++;
        if (sched_state !== 2'd0) begin
            n_errors++;
            $display("FAIL coinc_idle: got %0d want 0", sched_state);
        end
        enable_req = 1'b1;
        step();
        strobe_bpm(8'd250);
        push_n(7);
        bpm_in    = 8'd100;
        bpm_valid = 1'b1;
        push_pix();
        bpm_valid = 1'b0;
        n_checks++;
        if ({sched_state, BPM_estimate} !== {2'd2, 8'd200}) begin
            n_errors++;
            $display("FAIL coinc_load: got st=%0d bpm=%0d want st=2 bpm=200", sched_state, BPM_estimate);
        end
        push_n(8);
        n_checks++;
        if (BPM_estimate !== 8'd196) begin
            n_errors++;
            $display("FAIL coinc_next: got %0d want 196", BPM_estimate);
        end
    endtask

    task automatic test_reset_midframe();
        push_n(4);
        n_checks++;
        if (pixel_count !== 3'd4) begin
            n_errors++;
            $display("FAIL midframe_count: got %0d want 4", pixel_count);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if ({filter_enable, filter_mode, BPM_estimate, frame_done, pixel_count, bpm_stale, sched_state} !== 17'h0) begin
            n_errors++;
            $display("FAIL midframe_reset: got en=%b mode=%b bpm=%0d fd=%b cnt=%0d stale=%b st=%0d want all 0",
                     filter_enable, filter_mode, BPM_estimate, frame_done, pixel_count, bpm_stale, sched_state);
        end
        push_pix();
        n_checks++;
        if ({pixel_count, sched_state} !== {3'd1, 2'd1}) begin
            n_errors++;
            $display("FAIL restart_count: got cnt=%0d st=%0d want cnt=1 st=1", pixel_count, sched_state);
        end
        push_n(7);
        n_checks++;
        if ({sched_state, filter_enable, BPM_estimate, frame_done} !== {2'd2, 1'b1, 8'd0, 1'b1}) begin
            n_errors++;
            $display("FAIL post_reset_target: got st=%0d en=%b bpm=%0d fd=%b want st=2 en=1 bpm=0 fd=1",
                     sched_state, filter_enable, BPM_estimate, frame_done);
        end
    endtask

`ifdef FILTER_SCHED_SOF_RESYNC_EN
    task automatic test_sof();
        push_n(5);
        sof = 1'b1;
        step();
        sof = 1'b0;
        n_checks++;
        if ({pixel_count, sync_err_count, frame_done} !== {3'd0, 8'd1, 1'b0}) begin
            n_errors++;
            $display("FAIL sof_resync: got cnt=%0d err=%0d fd=%b want cnt=0 err=1 fd=0",
                     pixel_count, sync_err_count, frame_done);
        end
        push_n(3);
        sof = 1'b1;
        push_pix();
        sof = 1'b0;
        n_checks++;
        if ({pixel_count, sync_err_count, frame_done} !== {3'd1, 8'd2, 1'b0}) begin
            n_errors++;
            $display("FAIL sof_with_accept: got cnt=%0d err=%0d fd=%b want cnt=1 err=2 fd=0",
                     pixel_count, sync_err_count, frame_done);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        enable_req = 1'b0;
        mode_req   = 1'b0;
        bpm_in     = 8'd0;
        bpm_valid  = 1'b0;
        pix_valid  = 1'b0;
        pix_ready  = 1'b0;
`ifdef FILTER_SCHED_SOF_RESYNC_EN
        sof        = 1'b0;
`endif
        test_reset();
        test_first_enable();
        test_slew();
        test_mode_disable();
        test_stale();
        test_coincident();
        test_reset_midframe();
`ifdef FILTER_SCHED_SOF_RESYNC_EN
        test_sof();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/filter_frame_scheduler.md
Name: filter_frame_scheduler

Overview:
- Sequences configuration of the pixel-wise filter stage so that settings only ever change on frame boundaries. This prevents torn frames.
- Counts accepted pixels at the filter input. Latches asynchronous user/estimator requests (enable, mode, BPM). Applies them at end-of-frame.
- Slews the applied BPM toward its target by a bounded step per frame.
- Sits between the control/estimator logic and the filter's filter_enable, filter_mode and BPM_estimate inputs.

Parameters:
- IMG_W, 320, pixels per line.
- IMG_H, 240, lines per frame.
- MAX_BPM, 200, clamp ceiling for target and applied BPM.
- BPM_STEP, 4, max change of applied BPM per frame boundary.
- STALE_FRAMES, 8, frames without bpm_valid before the target decays to 0.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable_req  in  1  level; requested filter enable
- mode_req  in  1  level; requested filter mode
- bpm_in  in  8  BPM estimate from estimator
- bpm_valid  in  1  one-cycle strobe qualifying bpm_in
- pix_valid  in  1  tap of filter valid_in
- pix_ready  in  1  tap of filter module_ready
- filter_enable  out  1  to filter
- filter_mode  out  1  to filter
- BPM_estimate  out  8  applied BPM to filter
- frame_done  out  1  one-cycle pulse, registered, cycle after last pixel accepted
- pixel_count  out  $clog2(IMG_W*IMG_H)  accepted pixels in current frame
- bpm_stale  out  1  high while the target has decayed due to staleness
- sched_state  out  2  current FSM state encoding

Behaviour:
- Only clk and reset exist: one clock; reset is synchronous and active-high.
- Reset values: filter_enable=0, filter_mode=0, BPM_estimate=0, frame_done=0, pixel_count=0, bpm_stale=0, sched_state=IDLE. Internal target=0 and stale counter=0.
- Reset mid-frame discards the partial count. The next accepted pixel is pixel 0.
- Pixel accept: pix_valid && pix_ready in the same cycle. pixel_count increments on accept.
- End-of-frame (eof) is an accept while pixel_count == IMG_W*IMG_H-1. On eof, pixel_count wraps to 0 and frame_done pulses on the next cycle.
- BPM target capture: on bpm_valid, target <= min(bpm_in, MAX_BPM), the stale counter clears and bpm_stale clears.
- Boundary uses registered state: if bpm_valid coincides with eof, the boundary update uses the pre-capture target. The new target takes effect at the following boundary.
- Staleness: each eof without bpm_valid increments the stale counter, saturating at STALE_FRAMES. On reaching STALE_FRAMES, target <= 0 and bpm_stale <= 1.
- Applied BPM update at each eof, in states ACTIVE and DISARMING only:
  - if |target - applied| <= BPM_STEP, applied <= target;
  - otherwise applied moves by BPM_STEP toward target.
  - Compute in 9-bit unsigned with no wrap; result never exceeds MAX_BPM.
- FSM (sched_state encoding IDLE=0, ARMED=1, ACTIVE=2, DISARMING=3):
  - IDLE: outputs held disabled. enable_req=1 -> ARMED.
  - ARMED: enable_req=0 -> IDLE. On eof -> ACTIVE; at that edge filter_enable<=1, filter_mode<=mode_req, applied BPM <= target (no slew on first enable).
  - ACTIVE: on eof, filter_mode<=mode_req and the slew step is applied. enable_req=0 -> DISARMING.
  - DISARMING: enable_req=1 -> ACTIVE, with no output change. On eof -> IDLE; filter_enable<=0, BPM_estimate<=0.
  - If enable_req deasserts on the eof cycle in ACTIVE, the eof update applies and the state goes to DISARMING. Disable takes effect at the next boundary.
- mode_req changes mid-frame are never reflected before the next eof.
- Output latency: outputs change on the clock edge of the eof accept, so they are visible the cycle frame_done is high.

Optional Feature:
- Macro: FILTER_SCHED_SOF_RESYNC_EN.
- With the macro defined: adds input port sof (1 bit, one-cycle start-of-frame strobe).
  - sof forces pixel_count to 0. If an accept occurs in the same cycle, pixel_count = 1.
  - A sof arriving while pixel_count != 0 increments a saturating 8-bit output sync_err_count.
  - No eof is generated for the truncated frame.
- Without the macro: no sof port and no sync_err_count port. Framing relies purely on counting.

Decomposition:
- Package filter_sched_pkg:
  - sched_state_t enum (IDLE, ARMED, ACTIVE, DISARMING);
  - localparam FRAME_PIX = IMG_W*IMG_H default;
  - function bpm_slew(applied, target, step) returning the next applied value.
- One natural sub-module, bpm_slew_limiter: holds the target register, stale counter and applied register. Driven by the eof and bpm_valid strobes.
- FSM and pixel counter stay in the top module.

Test Plan:
- IMG_W=4, IMG_H=2. Reset, enable_req=1, bpm strobe 120, 8 accepts with pix_ready toggling -> filter_enable rises only on the 8th accept edge, BPM_estimate=120, frame_done pulses once, pixel_count=0.
- ACTIVE at BPM 120, bpm_in=140, BPM_STEP=4 -> BPM_estimate 124,128,…,140 over 5 boundaries, then holds. bpm_in=250 -> target clamps to 200.
- mode_req toggled at pixel 3 -> filter_mode changes exactly at the next eof. enable_req=0 at pixel 5 -> DISARMING, then IDLE at eof with filter_enable=0, BPM_estimate=0.
- No bpm_valid for 8 frames with STALE_FRAMES=8 -> bpm_stale=1 and BPM_estimate ramps down by 4 per frame to 0. A new bpm_valid clears bpm_stale.
- bpm_valid coincident with eof, and reset asserted at pixel 4 -> coincident value applied one boundary later. After reset, all outputs are at reset values and the count restarts at 0.
- With FILTER_SCHED_SOF_RESYNC_EN: sof at pixel 5 -> pixel_count=0, sync_err_count=1, no frame_done.
